// File: rtl/alu_pkg.sv
// Shared types and constants for the FP ALU issue/result sequencer.
// The divide-by-zero helper is only referenced when ALU_DIVZERO_CHECK_EN is defined.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_WAIT = 2'b01,
        SEQ_HOLD = 2'b10
    } seq_state_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;

    // One queued request: 2 + 32 + 32 = 66 bits.
    typedef struct packed {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    function automatic logic is_div_by_zero(input alu_op_t op, input logic [31:0] b);
        return (op == ALU_DIV) && (b[30:0] == 31'd0);
    endfunction

    // Signed infinity for x/0, quiet NaN for 0/0.
    function automatic logic [31:0] div_by_zero_result(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0) begin
            return FP_QNAN;
        end
        return {a[31] ^ b[31], FP_INF_EXP, 23'd0};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the sequencer. The slave modport is the
// sequencer itself; the master modport is its environment (requester, ALU and consumer).
interface alu_op_sequencer_if;
    import alu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    alu_op_t     req_op;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_t     alu_op;
    logic [31:0] alu_c;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_c;
    alu_op_t     rsp_op;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_c, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_c, rsp_op, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_c, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_c, rsp_op, rsp_err
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous show-ahead request FIFO (DEPTH x 66 bits) with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  alu_req_t push_data,
    input  logic     pop,
    output alu_req_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    alu_req_t        mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     wr_ptr_d;
    logic [AW:0]     rd_ptr_q;
    logic [AW:0]     rd_ptr_d;
    logic            do_push;
    logic            do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// In-order issue/result stage for the FP ALU: queues requests, holds operands for the
// op's fixed latency, then returns C. Define ALU_DIVZERO_CHECK_EN to short-circuit x/0.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 10
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus
);

    localparam int MAX_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int MAX_LAT = (MAX_AM > LAT_DIV) ? MAX_AM : LAT_DIV;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [31:0]        alu_a_q;
    logic [31:0]        alu_a_d;
    logic [31:0]        alu_b_q;
    logic [31:0]        alu_b_d;
    alu_op_t            alu_op_q;
    alu_op_t            alu_op_d;
    logic               rsp_valid_q;
    logic               rsp_valid_d;
    logic [31:0]        rsp_c_q;
    logic [31:0]        rsp_c_d;
    alu_op_t            rsp_op_q;
    alu_op_t            rsp_op_d;
`ifdef ALU_DIVZERO_CHECK_EN
    logic               dz_q;
    logic               dz_d;
    logic               rsp_err_q;
    logic               rsp_err_d;
`endif

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    alu_req_t           fifo_in;
    alu_req_t           fifo_head;
    logic               load;

    function automatic logic [CNT_W-1:0] lat_minus1(input alu_op_t op);
        case (op)
            ALU_MUL: return CNT_W'(LAT_MUL - 1);
            ALU_DIV: return CNT_W'(LAT_DIV - 1);
            default: return CNT_W'(LAT_ADD - 1);
        endcase
    endfunction

    // Ready is forced low during reset so nothing is accepted into a FIFO being cleared.
    assign bus.req_ready = !rst && !fifo_full;
    assign fifo_push     = bus.req_valid && bus.req_ready;
    assign fifo_in       = '{op: bus.req_op, a: bus.req_a, b: bus.req_b};

    alu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_c_d     = rsp_c_q;
        rsp_op_d    = rsp_op_q;
`ifdef ALU_DIVZERO_CHECK_EN
        dz_d        = dz_q;
        rsp_err_d   = rsp_err_q;
`endif
        fifo_pop    = 1'b0;
        load        = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                load = !fifo_empty;
            end
            SEQ_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_op_d    = alu_op_q;
                    state_d     = SEQ_HOLD;
`ifdef ALU_DIVZERO_CHECK_EN
                    rsp_err_d   = dz_q;
                    rsp_c_d     = dz_q ? div_by_zero_result(alu_a_q, alu_b_q) : bus.alu_c;
`else
                    rsp_c_d     = bus.alu_c;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SEQ_HOLD: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        // A pop always lands in WAIT; a trapped x/0 waits zero cycles there.
        if (load) begin
            fifo_pop = 1'b1;
            alu_a_d  = fifo_head.a;
            alu_b_d  = fifo_head.b;
            alu_op_d = fifo_head.op;
            cnt_d    = lat_minus1(fifo_head.op);
            state_d  = SEQ_WAIT;
`ifdef ALU_DIVZERO_CHECK_EN
            dz_d     = is_div_by_zero(fifo_head.op, fifo_head.b);
            if (dz_d) begin
                cnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_ADD;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_op_q    <= ALU_ADD;
`ifdef ALU_DIVZERO_CHECK_EN
            dz_q        <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            rsp_op_q    <= rsp_op_d;
`ifdef ALU_DIVZERO_CHECK_EN
            dz_q        <= dz_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_op    = rsp_op_q;
`ifdef ALU_DIVZERO_CHECK_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a latency-aware stand-in ALU; honours
// ALU_DIVZERO_CHECK_EN when the design is built with it.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int LAT_ADD = 3;
    localparam int LAT_MUL = 4;
    localparam int LAT_DIV = 10;
`ifdef ALU_DIVZERO_CHECK_EN
    localparam int DZ_LAT  = 2;
`else
    localparam int DZ_LAT  = LAT_DIV + 1;
`endif

    typedef struct {
        logic [31:0] c;
        alu_op_t     op;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    int          rise_q[$];
    exp_t        mon_e;
    logic        prev_valid = 1'b0;
    bit          rand_ready = 1'b0;
    logic        force_ready = 1'b1;
    logic [65:0] last_ops = '0;
    int          age = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer_if bus();

    alu_op_sequencer #(
        .DEPTH   (DEPTH),
        .LAT_ADD (LAT_ADD),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int lat_of(input alu_op_t op);
        case (op)
            ALU_MUL: return LAT_MUL;
            ALU_DIV: return LAT_DIV;
            default: return LAT_ADD;
        endcase
    endfunction

    // Stand-in ALU: exact for 1.0+2.0, otherwise an operand hash the sequencer must pass through.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input alu_op_t op);
        if (op == ALU_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return {a[15:0], a[31:16]} ^ (b + {30'd0, op}) ^ 32'h5A5A_0000;
    endfunction

    function automatic exp_t expect_rsp(input logic [31:0] a, input logic [31:0] b, input alu_op_t op);
        exp_t e;
        e.op  = op;
        e.err = 1'b0;
        e.c   = alu_model(a, b, op);
`ifdef ALU_DIVZERO_CHECK_EN
        if (op == ALU_DIV && b[30:0] == 31'd0) begin
            e.err = 1'b1;
            e.c   = (a[30:0] == 31'd0) ? 32'h7FC0_0000 : {a[31] ^ b[31], 8'hFF, 23'd0};
        end
`endif
        return e;
    endfunction

    // C is only correct once the operands have been steady for LAT cycles; before that it is garbage.
    always @(negedge clk) begin
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== last_ops) begin
            last_ops = {bus.alu_a, bus.alu_b, bus.alu_op};
            age      = 0;
        end else if (age < 1000) begin
            age++;
        end
    end
    assign bus.alu_c = (age >= lat_of(bus.alu_op) - 1) ? alu_model(bus.alu_a, bus.alu_b, bus.alu_op)
                                                       : ~alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    always @(posedge clk) begin
        #2;
        bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: a response is checked at the half cycle before the edge that consumes it.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp_valid && !prev_valid) rise_q.push_back(cyc);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("rsp_c", bus.rsp_c, mon_e.c);
                    checkOutput("rsp_op", 32'(bus.rsp_op), 32'(mon_e.op));
                    checkOutput("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                end
            end
        end
        prev_valid = rst ? 1'b0 : bus.rsp_valid;
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input alu_op_t op,
                                 input int max_wait, output bit accepted, output int acc_cyc);
        accepted      = 1'b0;
        acc_cyc       = -1;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        for (int i = 0; i < max_wait && !accepted; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk); #1;
                accepted = 1'b1;
                acc_cyc  = cyc;
                exp_q.push_back(expect_rsp(a, b, op));
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput("ready_in_reset", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic waitDrain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk); #1;
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic waitRise(input int n, input int max_cycles);
        for (int i = 0; i < max_cycles && rise_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("rise_seen", 32'(rise_q.size() >= n), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          acc;
        int          ac;
        int          n_acc;
        int          lat;
        logic [31:0] ra;
        logic [31:0] rb;
        alu_op_t     rop;

        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = ALU_ADD;

        // Reset state
        applyReset(2);
        @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_rsp_c", bus.rsp_c, 32'd0);
        @(posedge clk); #1;

        // Single add into an idle block
        rise_q.delete();
        applyStimulus(32'h3F80_0000, 32'h4000_0000, ALU_ADD, 10, acc, ac);
        checkOutput("add_accepted", 32'(acc), 32'd1);
        waitRise(1, 30);
        lat = (rise_q.size() > 0) ? rise_q[0] - ac : -1;
        checkOutput("add_latency", 32'(lat), 32'(LAT_ADD + 1));
        waitDrain(50);

        // Backpressure: DEPTH queued plus one in flight
        force_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom; rb = $urandom;
            applyStimulus(ra, rb, ALU_MUL, 5, acc, ac);
            n_acc += int'(acc);
        end
        checkOutput("bp_accepted", 32'(n_acc), 32'd5);
        ra = $urandom; rb = $urandom;
        applyStimulus(ra, rb, ALU_MUL, 15, acc, ac);
        checkOutput("bp_sixth_refused", 32'(acc), 32'd0);
        @(negedge clk);
        checkOutput("bp_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        force_ready = 1'b1;
        waitDrain(300);

        // Back-to-back muls with the consumer always ready
        repeat (2) begin @(posedge clk); #1; end
        rise_q.delete();
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            applyStimulus(ra, rb, ALU_MUL, 5, acc, ac);
        end
        waitDrain(100);
        checkOutput("b2b_count", 32'(rise_q.size()), 32'd3);
        lat = (rise_q.size() >= 2) ? rise_q[1] - rise_q[0] : -1;
        checkOutput("b2b_gap1", 32'(lat), 32'(LAT_MUL + 1));
        lat = (rise_q.size() >= 3) ? rise_q[2] - rise_q[1] : -1;
        checkOutput("b2b_gap2", 32'(lat), 32'(LAT_MUL + 1));

        // Divide by negative zero
        rise_q.delete();
        applyStimulus(32'h3F80_0000, 32'h8000_0000, ALU_DIV, 5, acc, ac);
        waitRise(1, 30);
        lat = (rise_q.size() > 0) ? rise_q[0] - ac : -1;
        checkOutput("div0_latency", 32'(lat), 32'(DZ_LAT));
        waitDrain(50);

        // Reset while a div waits with two more queued
        rise_q.delete();
        ra = $urandom;
        applyStimulus(ra, 32'h4000_0000, ALU_DIV, 5, acc, ac);
        applyStimulus(ra, 32'h3F80_0000, ALU_ADD, 5, acc, ac);
        applyStimulus(ra, 32'h3F80_0000, ALU_SUB, 5, acc, ac);
        repeat (2) begin @(posedge clk); #1; end
        applyReset(1);
        @(negedge clk);
        checkOutput("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        repeat (20) begin @(posedge clk); #1; end
        checkOutput("rst_mid_no_rsp", 32'(rise_q.size()), 32'd0);

        // Randomized traffic with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = alu_op_t'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                rb[30:0] = 31'd0;
                if ($urandom_range(0, 1) == 1) ra[30:0] = 31'd0;
            end
            applyStimulus(ra, rb, rop, 300, acc, ac);
            checkOutput("rand_accepted", 32'(acc), 32'd1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        waitDrain(3000);
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
